// File: rtl/memory_fifo_pkg.sv
// Shared sizes and FSM encoding for the external-memory byte FIFO controller.
package memory_fifo_pkg;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FETCH = 1'b1
    } state_e;
endpackage

// File: rtl/memory_fifo_ctrl.sv
// 8-entry byte FIFO kept in an external single-port memory, plus one output register.
// Optional `level` output (count + out_valid) enabled by macro MEMORY_FIFO_CTRL_LEVEL_EN.
module memory_fifo_ctrl
    import memory_fifo_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              full,
    output logic              empty
`ifdef MEMORY_FIFO_CTRL_LEVEL_EN
    ,
    output logic [CNT_W-1:0]  level
`endif
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              full_int;
    logic              read_issue;

    assign full_int   = (count_q == CNT_W'(DEPTH));
    // Refilling the output register takes priority over accepting a new byte.
    assign read_issue = (state_q == S_IDLE) && (count_q != '0) && (!out_valid_q || out_ready);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        mem_we      = 1'b0;
        mem_addr    = wr_ptr_q;
        in_ready    = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (read_issue) begin
                    mem_addr = rd_ptr_q;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    count_d  = count_q - 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    in_ready = !full_int;
                    mem_we   = in_valid && !full_int;
                    if (in_valid && !full_int) begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        count_d  = count_q + 1'b1;
                    end
                end
            end
            S_FETCH: begin
                // rd_ptr already advanced; keep presenting the address being read.
                mem_addr    = rd_ptr_q - 1'b1;
                out_data_d  = mem_dout;
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (rst) begin
            mem_we   = 1'b0;
            in_ready = 1'b0;
            mem_addr = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign mem_din   = in_data;
    assign full      = !rst && full_int;
    assign empty     = rst || ((count_q == '0) && !out_valid_q);

`ifdef MEMORY_FIFO_CTRL_LEVEL_EN
    assign level = rst ? '0 : (count_q + CNT_W'(out_valid_q));
`endif

endmodule
